column_approx_divider: RTL and testbench

//  Sequential approximate restoring divider: the inverse path of the column-truncated

---
 rtl/approx_pkg.sv | 34 +++
 rtl/column_approx_div_step.sv | 31 +++
 rtl/column_approx_divider.sv | 140 ++++++++++++++
 tb/tb_column_approx_divider.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/approx_pkg.sv
// Shared definitions for the column-truncated multiplier/divider family.
package approx_pkg;

  // Operation phases of the sequential divider.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } div_state_e;

  // Narrowest operand width the truncated datapaths support.
  localparam int unsigned LENGTH_MIN = 2;
  // Widest operand width whose product domain fits trunc_low's 64-bit container.
  localparam int unsigned LENGTH_MAX = 32;

  // Zero the n least-significant bits of x; n >= 64 clears everything.
  function automatic logic [63:0] trunc_low(input logic [63:0] x, input int unsigned n);
    logic [63:0] mask;
    mask = (n >= 64) ? 64'd0 : (~64'd0 << n);
    return x & mask;
  endfunction

  // Truncation point must sit inside the upper half of the product domain.
  function automatic bit theta_legal(input int unsigned length, input int unsigned theta);
    return (length >= LENGTH_MIN) && (length <= LENGTH_MAX) &&
           (theta >= length) && (theta <= 2 * length - 1);
  endfunction

  // Number of low dividend columns dropped for a given LENGTH/THETA pair.
  function automatic int unsigned trunc_cols(input int unsigned length, input int unsigned theta);
    return (theta_legal(length, theta) && (theta > length)) ? (theta - length) : 0;
  endfunction

endpackage

// File: rtl/column_approx_div_step.sv
// One restoring-division step: shift in the next dividend bit, subtract if it fits.
module column_approx_div_step #(
  parameter int unsigned LENGTH = 8
) (
  input  logic [LENGTH-1:0] rem_i,
  input  logic              bit_i,
  input  logic [LENGTH-1:0] divisor_i,
  output logic [LENGTH-1:0] rem_c_o,
  output logic              qbit_c_o
);

  localparam int unsigned TW = LENGTH + 1;

  logic [TW-1:0] trial_c;
  logic [TW-1:0] diff_c;
  logic [TW-1:0] divisor_ext_c;

  // Partial remainder extended by one bit so the compare never wraps.
  always_comb begin
    trial_c       = {rem_i, bit_i};
    divisor_ext_c = {1'b0, divisor_i};
    diff_c        = trial_c - divisor_ext_c;
    qbit_c_o      = 1'b0;
    rem_c_o       = LENGTH'(trial_c);
    if (trial_c >= divisor_ext_c) begin
      qbit_c_o = 1'b1;
      rem_c_o  = LENGTH'(diff_c);
    end
  end

endmodule

// File: rtl/column_approx_divider.sv
// Sequential approximate restoring divider over a column-truncated dividend.
module column_approx_divider
  import approx_pkg::*;
#(
  parameter int unsigned LENGTH = 8,
  parameter int unsigned THETA  = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2*LENGTH-1:0]   dividend,
  input  logic [LENGTH-1:0]     divisor,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [LENGTH-1:0]     quotient,
  output logic [LENGTH-1:0]     remainder,
  output logic                  overflow
);

  localparam int unsigned DW    = 2 * LENGTH;
  localparam int unsigned CW    = $clog2(LENGTH + 1);
  localparam int unsigned TRUNC = trunc_cols(LENGTH, THETA);

  div_state_e        state_q, state_d;
  logic [LENGTH-1:0] rem_q, rem_d;
  logic [LENGTH-1:0] low_q, low_d;
  logic [LENGTH-1:0] div_q, div_d;
  logic [LENGTH-1:0] quo_q, quo_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              ovf_q, ovf_d;
  logic              in_ready_q, in_ready_d;
  logic              out_valid_q, out_valid_d;

  logic [DW-1:0]     dt_c;
  logic [LENGTH-1:0] dt_hi_c;
  logic [LENGTH-1:0] dt_lo_c;
  logic [LENGTH-1:0] step_rem_c;
  logic              step_qbit_c;

  // Drop the low product columns exactly as the truncated multipliers do.
  always_comb begin
    dt_c    = DW'(trunc_low(64'(dividend), TRUNC));
    dt_hi_c = dt_c[DW-1:LENGTH];
    dt_lo_c = dt_c[LENGTH-1:0];
  end

  column_approx_div_step #(
    .LENGTH(LENGTH)
  ) u_step (
    .rem_i    (rem_q),
    .bit_i    (low_q[LENGTH-1]),
    .divisor_i(div_q),
    .rem_c_o  (step_rem_c),
    .qbit_c_o (step_qbit_c)
  );

  // Next-state and datapath update for IDLE -> BUSY -> DONE -> IDLE.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    low_d   = low_q;
    div_d   = div_q;
    quo_d   = quo_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          div_d = divisor;
          if (dt_hi_c >= divisor) begin
            // Quotient cannot fit (includes divide by zero): answer immediately.
            state_d = DONE;
            quo_d   = '1;
            rem_d   = '0;
            ovf_d   = 1'b1;
          end else begin
            state_d = BUSY;
            rem_d   = dt_hi_c;
            low_d   = dt_lo_c;
            quo_d   = '0;
            ovf_d   = 1'b0;
            cnt_d   = CW'(LENGTH);
          end
        end
      end
      BUSY: begin
        rem_d = step_rem_c;
        low_d = low_q << 1;
        quo_d = {quo_q[LENGTH-2:0], step_qbit_c};
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

  // State, datapath and handshake registers; reset discards any in-flight op.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rem_q       <= '0;
      low_q       <= '0;
      div_q       <= '0;
      quo_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      low_q       <= low_d;
      div_q       <= div_d;
      quo_q       <= quo_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign quotient  = quo_q;
  assign remainder = rem_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_column_approx_divider.sv
// Directed bench for column_approx_divider (LENGTH=8, THETA=10).
module tb_column_approx_divider;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] dividend;
  logic [7:0]  divisor;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  quotient;
  logic [7:0]  remainder;
  logic        overflow;

  int n_checks;
  int n_fail;

  column_approx_divider #(
    .LENGTH(8),
    .THETA (10)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .dividend (dividend),
    .divisor  (divisor),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .quotient (quotient),
    .remainder(remainder),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one operation and hold it through the accepting edge.
  task automatic start_op(input logic [15:0] a, input logic [7:0] b);
    @(negedge clk);
    in_valid = 1'b1;
    dividend = a;
    divisor  = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    dividend = 16'($urandom);
    divisor  = 8'($urandom);
  endtask

  // Count edges from the accepting edge until out_valid, bounded.
  task automatic wait_result(output int cycles);
    cycles = 1;
    while (out_valid !== 1'b1 && cycles < 40) begin
      @(posedge clk);
      #1;
      cycles++;
    end
  endtask

  // Accept the presented result with a one-cycle out_ready pulse.
  task automatic consume();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = '0;
    divisor   = '0;
    #12;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_checks++; if (quotient !== 8'd0) begin n_fail++; $display("FAIL reset_quotient: got %0d want 0", quotient); end
    n_checks++; if (remainder !== 8'd0) begin n_fail++; $display("FAIL reset_remainder: got %0d want 0", remainder); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b want 0", overflow); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    int lat;
    start_op(16'd1000, 8'd25);
    wait_result(lat);
    n_checks++; if (lat != 9) begin n_fail++; $display("FAIL basic_latency: got %0d want 9", lat); end
    n_checks++; if (quotient !== 8'd40) begin n_fail++; $display("FAIL basic_quotient: got %0d want 40", quotient); end
    n_checks++; if (remainder !== 8'd0) begin n_fail++; $display("FAIL basic_remainder: got %0d want 0", remainder); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL basic_overflow: got %b want 0", overflow); end
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL basic_in_ready_done: got %b want 0", in_ready); end
    consume();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_out_valid_after: got %b want 0", out_valid); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL basic_in_ready_after: got %b want 1", in_ready); end
  endtask

  task automatic test_truncation();
    int lat;
    start_op(16'd1003, 8'd25);
    wait_result(lat);
    n_checks++; if (quotient !== 8'd40) begin n_fail++; $display("FAIL trunc_quotient: got %0d want 40", quotient); end
    n_checks++; if (remainder !== 8'd0) begin n_fail++; $display("FAIL trunc_remainder: got %0d want 0", remainder); end
    consume();
  endtask

  task automatic test_max();
    int lat;
    start_op(16'hFEFF, 8'd255);
    wait_result(lat);
    n_checks++; if (lat != 9) begin n_fail++; $display("FAIL max_latency: got %0d want 9", lat); end
    n_checks++; if (quotient !== 8'd255) begin n_fail++; $display("FAIL max_quotient: got %0d want 255", quotient); end
    n_checks++; if (remainder !== 8'd251) begin n_fail++; $display("FAIL max_remainder: got %0d want 251", remainder); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL max_overflow: got %b want 0", overflow); end
    consume();
  endtask

  task automatic test_overflow();
    logic [15:0] a_tab [2];
    logic [7:0]  b_tab [2];
    int lat;
    a_tab[0] = 16'h1900; b_tab[0] = 8'd25;
    a_tab[1] = 16'd5;    b_tab[1] = 8'd0;
    for (int i = 0; i < 2; i++) begin
      start_op(a_tab[i], b_tab[i]);
      wait_result(lat);
      n_checks++; if (lat != 1) begin n_fail++; $display("FAIL ovf%0d_latency: got %0d want 1", i, lat); end
      n_checks++; if (quotient !== 8'hFF) begin n_fail++; $display("FAIL ovf%0d_quotient: got %0h want ff", i, quotient); end
      n_checks++; if (remainder !== 8'd0) begin n_fail++; $display("FAIL ovf%0d_remainder: got %0d want 0", i, remainder); end
      n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf%0d_flag: got %b want 1", i, overflow); end
      consume();
    end
  endtask

  task automatic test_vectors();
    logic [15:0] a_tab [4];
    logic [7:0]  b_tab [4];
    logic [7:0]  q_tab [4];
    logic [7:0]  r_tab [4];
    int lat;
    // 200/7; 60000/250; 0x03FF->1020 /4; 0x0103->256 /3
    a_tab[0] = 16'd200;   b_tab[0] = 8'd7;   q_tab[0] = 8'd28;  r_tab[0] = 8'd4;
    a_tab[1] = 16'd60000; b_tab[1] = 8'd250; q_tab[1] = 8'd240; r_tab[1] = 8'd0;
    a_tab[2] = 16'h03FF;  b_tab[2] = 8'd4;   q_tab[2] = 8'd255; r_tab[2] = 8'd0;
    a_tab[3] = 16'h0103;  b_tab[3] = 8'd3;   q_tab[3] = 8'd85;  r_tab[3] = 8'd1;
    for (int i = 0; i < 4; i++) begin
      start_op(a_tab[i], b_tab[i]);
      wait_result(lat);
      n_checks++; if (quotient !== q_tab[i]) begin n_fail++; $display("FAIL vec%0d_quotient: got %0d want %0d", i, quotient, q_tab[i]); end
      n_checks++; if (remainder !== r_tab[i]) begin n_fail++; $display("FAIL vec%0d_remainder: got %0d want %0d", i, remainder, r_tab[i]); end
      n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL vec%0d_overflow: got %b want 0", i, overflow); end
      consume();
    end
  endtask

  task automatic test_backpressure();
    int lat;
    start_op(16'd1000, 8'd25);
    wait_result(lat);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      in_valid = c[0];
      dividend = 16'd5;
      divisor  = 8'd0;
      @(posedge clk);
      #1;
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp%0d_out_valid: got %b want 1", c, out_valid); end
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp%0d_in_ready: got %b want 0", c, in_ready); end
      n_checks++; if (quotient !== 8'd40) begin n_fail++; $display("FAIL bp%0d_quotient: got %0d want 40", c, quotient); end
      n_checks++; if (remainder !== 8'd0) begin n_fail++; $display("FAIL bp%0d_remainder: got %0d want 0", c, remainder); end
      n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL bp%0d_overflow: got %b want 0", c, overflow); end
    end
    @(negedge clk);
    in_valid = 1'b0;
    consume();
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_no_repeat%0d: got %b want 0", c, out_valid); end
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_idle_ready%0d: got %b want 1", c, in_ready); end
    end
  endtask

  task automatic test_reset_mid_busy();
    int lat;
    start_op(16'hFEFF, 8'd255);
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL abort_out_valid: got %b want 0", out_valid); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL abort_in_ready: got %b want 1", in_ready); end
    n_checks++; if (quotient !== 8'd0) begin n_fail++; $display("FAIL abort_quotient: got %0d want 0", quotient); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) begin
      @(posedge clk);
      #1;
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL abort_ghost_result: got %b want 0", out_valid); end
    end
    start_op(16'd1000, 8'd25);
    wait_result(lat);
    n_checks++; if (lat != 9) begin n_fail++; $display("FAIL abort_next_latency: got %0d want 9", lat); end
    n_checks++; if (quotient !== 8'd40) begin n_fail++; $display("FAIL abort_next_quotient: got %0d want 40", quotient); end
    n_checks++; if (remainder !== 8'd0) begin n_fail++; $display("FAIL abort_next_remainder: got %0d want 0", remainder); end
    consume();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_basic();
    test_truncation();
    test_max();
    test_overflow();
    test_vectors();
    test_backpressure();
    test_reset_mid_busy();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
